// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch-address generator.
// Contents: FSM state enum, redirect-source enum, default increment and reset vector.
// Imported by the redirect mux, the top and the bench.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        IDLE
    } state_t;

    // Listed in priority order, highest first.
    typedef enum logic [1:0] {
        SRC_TRAP,
        SRC_EX,
        SRC_PRED,
        SRC_SEQ
    } src_t;

    localparam logic [31:0] FETCH_INC       = 32'd4;
    localparam logic [31:0] FETCH_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Bundle between the fetch-address generator and its surroundings.
// Carries the imem request channel, the IF-stage handoff, and the redirect inputs.
// master: the generator side; slave: memory / IF / EX / trap side.
interface fetch_pc_gen_if;

    // imem request channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;

    // IF-stage output and prediction input
    logic [31:0] PC_IF;
    logic        valid_out;
    logic        ready_in;
    logic        jump_pred_IF;
    logic [31:0] jump_addr_IF;

    // redirect sources
    logic        redir_EX;
    logic [31:0] redir_addr_EX;
    logic        trap_taken;
    logic [31:0] trap_addr;
    logic        halt_req;

    modport master (
        output imem_req, imem_addr, PC_IF, valid_out,
        input  imem_gnt, ready_in, jump_pred_IF, jump_addr_IF,
               redir_EX, redir_addr_EX, trap_taken, trap_addr, halt_req
    );

    modport slave (
        input  imem_req, imem_addr, PC_IF, valid_out,
        output imem_gnt, ready_in, jump_pred_IF, jump_addr_IF,
               redir_EX, redir_addr_EX, trap_taken, trap_addr, halt_req
    );

endinterface

// File: rtl/fetch_pc_gen_redirect_mux.sv
// Priority select of the next fetch address: trap > EX redirect > prediction > sequential.
// Latency: purely combinational.
// Backpressure: none; pred_take must already be qualified with the IF handoff.
module fetch_redirect_mux
    import fetch_pkg::*;
(
    input  logic        trap_taken,
    input  logic [31:0] trap_addr,
    input  logic        redir_EX,
    input  logic [31:0] redir_addr_EX,
    input  logic        pred_take,
    input  logic [31:0] jump_addr_IF,
    input  logic [31:0] seq_addr,
    output logic        redirect,
    output logic [31:0] target
);

    src_t src;

    always_comb begin
        if (trap_taken)     src = SRC_TRAP;
        else if (redir_EX)  src = SRC_EX;
        else if (pred_take) src = SRC_PRED;
        else                src = SRC_SEQ;
    end

    // Targets pass through untouched, low bits included.
    always_comb begin
        target = seq_addr;
        case (src)
            SRC_TRAP: target = trap_addr;
            SRC_EX:   target = redir_addr_EX;
            SRC_PRED: target = jump_addr_IF;
            default:  target = seq_addr;
        endcase
    end

    assign redirect = (src != SRC_SEQ);

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-address generator: issues fetch addresses to imem and presents PC_IF to IF.
// Latency: a redirect is visible on imem_addr the next cycle; accepted address reaches PC_IF one cycle after grant.
// Backpressure: request held stable until imem_gnt (only a redirect may change it); no request while IF holds an unconsumed PC.
// Ports: clk, reset (sync, active-high), bus (fetch_pc_gen_if.master).
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = FETCH_RESET_VEC,
    parameter logic [31:0] INC       = FETCH_INC
)
(
    input  logic            clk,
    input  logic            reset,
    fetch_pc_gen_if.master  bus
);

    state_t      state;
    logic [31:0] fetch_addr;
    logic [31:0] pc_if;
    logic        valid_q;

    logic        accept;
    logic        handoff;
    logic        pred_take;
    logic        redirect;
    logic [31:0] target;
    logic        req;

    // In RUN a new fetch may go out whenever the IF slot is empty or draining now.
    always_comb begin
        req = 1'b0;
        if (state == RUN) req = !(valid_q && !bus.ready_in);
    end

    assign accept    = req && bus.imem_gnt;
    assign handoff   = valid_q && bus.ready_in;
    assign pred_take = handoff && bus.jump_pred_IF;

    fetch_redirect_mux u_mux (
        .trap_taken    (bus.trap_taken),
        .trap_addr     (bus.trap_addr),
        .redir_EX      (bus.redir_EX),
        .redir_addr_EX (bus.redir_addr_EX),
        .pred_take     (pred_take),
        .jump_addr_IF  (bus.jump_addr_IF),
        .seq_addr      (fetch_addr + INC),
        .redirect      (redirect),
        .target        (target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            fetch_addr <= RESET_VEC;
            pc_if      <= RESET_VEC;
            valid_q    <= 1'b0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (!redirect && bus.halt_req) state <= IDLE;
                IDLE:    if (bus.trap_taken) state <= RUN;
                default: state <= BOOT;
            endcase

            if (redirect) begin
                // Any same-cycle accept is squashed: the fetched word is on the wrong path.
                fetch_addr <= target;
                valid_q    <= 1'b0;
            end else if (state == RUN && bus.halt_req) begin
                // Halting drops a same-cycle accept so fetch_addr resumes from the same place.
                valid_q    <= 1'b0;
            end else if (accept) begin
                pc_if      <= fetch_addr;
                valid_q    <= 1'b1;
                fetch_addr <= target;
            end else if (handoff) begin
                valid_q    <= 1'b0;
            end
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_addr;
    assign bus.PC_IF     = pc_if;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: boot, stall, prediction, redirect priority,
// abortable requests, halt/trap, address wrap and mid-run reset.
module tb_fetch_pc_gen;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic saw_bad = 1'b0;

    fetch_pc_gen_if bus ();

    fetch_pc_gen #(.RESET_VEC(32'h0000_0000), .INC(32'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Squashed or aborted addresses must never be presented to IF.
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1 && (bus.PC_IF === 32'h14 || bus.PC_IF === 32'h20 || bus.PC_IF === 32'h200))
            saw_bad <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.imem_gnt      = 1'b1;
        bus.ready_in      = 1'b1;
        bus.jump_pred_IF  = 1'b0;
        bus.jump_addr_IF  = 32'h0;
        bus.redir_EX      = 1'b0;
        bus.redir_addr_EX = 32'h0;
        bus.trap_taken    = 1'b0;
        bus.trap_addr     = 32'h0;
        bus.halt_req      = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req",   {31'b0, bus.imem_req},  32'h0);
        chk("rst_valid", {31'b0, bus.valid_out}, 32'h0);
        chk("rst_pc",    bus.PC_IF,     32'h0);
        chk("rst_addr",  bus.imem_addr, 32'h0);

        // Boot and sequential fetch
        reset = 1'b0; #1;
        chk("boot_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        chk("run_req",   {31'b0, bus.imem_req},  32'h1);
        chk("seq_a0",    bus.imem_addr, 32'h0);
        chk("seq_v0",    {31'b0, bus.valid_out}, 32'h0);
        tick();
        chk("seq_a4",    bus.imem_addr, 32'h4);
        chk("seq_pc0",   bus.PC_IF,     32'h0);
        chk("seq_v1",    {31'b0, bus.valid_out}, 32'h1);
        tick();
        chk("seq_a8",    bus.imem_addr, 32'h8);
        chk("seq_pc4",   bus.PC_IF,     32'h4);
        tick();
        chk("seq_pc8",   bus.PC_IF,     32'h8);

        // IF stall
        bus.ready_in = 1'b0; #1;
        chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req_h", {31'b0, bus.imem_req}, 32'h0);
            chk("stall_pc",    bus.PC_IF,     32'h8);
            chk("stall_addr",  bus.imem_addr, 32'hC);
        end
        bus.ready_in = 1'b1; #1;
        chk("resume_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("resume_addr", bus.imem_addr, 32'hC);
        tick();
        chk("resume_pcC",  bus.PC_IF, 32'hC);
        tick();
        chk("pc10",        bus.PC_IF, 32'h10);
        chk("addr14",      bus.imem_addr, 32'h14);

        // Predicted taken at handoff
        bus.jump_pred_IF = 1'b1; bus.jump_addr_IF = 32'h40;
        tick();
        bus.jump_pred_IF = 1'b0;
        chk("pred_valid", {31'b0, bus.valid_out}, 32'h0);
        chk("pred_addr",  bus.imem_addr, 32'h40);
        chk("pred_pc",    bus.PC_IF,     32'h10);
        tick();
        chk("pred_pc40",  bus.PC_IF, 32'h40);
        chk("pred_v",     {31'b0, bus.valid_out}, 32'h1);

        // Redirect priority
        bus.trap_taken = 1'b1; bus.trap_addr = 32'h100;
        bus.redir_EX = 1'b1; bus.redir_addr_EX = 32'h200;
        bus.jump_pred_IF = 1'b1; bus.jump_addr_IF = 32'h40;
        tick();
        bus.trap_taken = 1'b0; bus.redir_EX = 1'b0; bus.jump_pred_IF = 1'b0;
        chk("prio_trap",  bus.imem_addr, 32'h100);
        chk("prio_trapv", {31'b0, bus.valid_out}, 32'h0);
        tick();
        chk("pc100", bus.PC_IF, 32'h100);
        bus.redir_EX = 1'b1; bus.redir_addr_EX = 32'h200;
        bus.jump_pred_IF = 1'b1; bus.jump_addr_IF = 32'h40;
        tick();
        bus.redir_EX = 1'b0; bus.jump_pred_IF = 1'b0;
        chk("prio_ex", bus.imem_addr, 32'h200);

        // Abortable request
        bus.redir_EX = 1'b1; bus.redir_addr_EX = 32'h20;
        tick();
        bus.redir_EX = 1'b0; bus.imem_gnt = 1'b0; #1;
        chk("pend_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("pend_addr", bus.imem_addr, 32'h20);
        tick();
        chk("hold_addr1", bus.imem_addr, 32'h20);
        tick();
        chk("hold_addr2", bus.imem_addr, 32'h20);
        chk("hold_v",     {31'b0, bus.valid_out}, 32'h0);
        bus.redir_EX = 1'b1; bus.redir_addr_EX = 32'h80;
        tick();
        bus.redir_EX = 1'b0; bus.imem_gnt = 1'b1;
        chk("abort_addr", bus.imem_addr, 32'h80);
        tick();
        chk("abort_pc80", bus.PC_IF, 32'h80);

        // Halt, then trap out of IDLE
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        chk("halt_req",   {31'b0, bus.imem_req},  32'h0);
        chk("halt_valid", {31'b0, bus.valid_out}, 32'h0);
        chk("halt_addr",  bus.imem_addr, 32'h84);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_req", {31'b0, bus.imem_req}, 32'h0);
        end
        bus.trap_taken = 1'b1; bus.trap_addr = 32'h300;
        tick();
        bus.trap_taken = 1'b0;
        chk("wake_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("wake_addr", bus.imem_addr, 32'h300);
        tick();
        chk("wake_pc", bus.PC_IF, 32'h300);

        // Halt together with trap: trap wins, stays running
        bus.halt_req = 1'b1; bus.trap_taken = 1'b1; bus.trap_addr = 32'h500;
        tick();
        bus.halt_req = 1'b0; bus.trap_taken = 1'b0; #1;
        chk("ht_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("ht_addr", bus.imem_addr, 32'h500);

        // Prediction ignored while IF is stalled
        tick();
        chk("pc500", bus.PC_IF, 32'h500);
        bus.ready_in = 1'b0; bus.jump_pred_IF = 1'b1; bus.jump_addr_IF = 32'h40;
        tick();
        chk("nopred_pc",   bus.PC_IF, 32'h500);
        chk("nopred_addr", bus.imem_addr, 32'h504);
        chk("nopred_v",    {31'b0, bus.valid_out}, 32'h1);
        bus.ready_in = 1'b1; bus.jump_pred_IF = 1'b0;

        // Wrap at top of address space
        bus.redir_EX = 1'b1; bus.redir_addr_EX = 32'hFFFF_FFFC;
        tick();
        bus.redir_EX = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc",   bus.PC_IF,     32'hFFFF_FFFC);
        chk("wrap_next", bus.imem_addr, 32'h0);
        tick();
        chk("wrap_pc0",  bus.PC_IF,     32'h0);
        tick();
        chk("pre_rst_req", {31'b0, bus.imem_req}, 32'h1);

        // Reset mid-operation
        reset = 1'b1;
        tick();
        chk("mrst_req",   {31'b0, bus.imem_req},  32'h0);
        chk("mrst_valid", {31'b0, bus.valid_out}, 32'h0);
        chk("mrst_pc",    bus.PC_IF,     32'h0);
        chk("mrst_addr",  bus.imem_addr, 32'h0);
        reset = 1'b0; #1;
        chk("mrst_boot", {31'b0, bus.imem_req}, 32'h0);
        tick();
        chk("mrst_run",  {31'b0, bus.imem_req}, 32'h1);
        chk("mrst_a0",   bus.imem_addr, 32'h0);
        tick();
        chk("mrst_pc0",  bus.PC_IF, 32'h0);
        chk("mrst_v",    {31'b0, bus.valid_out}, 32'h1);

        tick();
        chk("no_squashed_pc", {31'b0, saw_bad}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-address generator directly upstream of the gshare branch predictor and IF stage.
- Selects the next instruction address from five sources, in priority order: reset vector, trap entry, EX mispredict/redirect, IF prediction, sequential PC+4.
- Issues that address to instruction memory over a valid/ready request.
- Presents the accepted address as PC_IF, with valid_out, to the IF stage; that PC_IF feeds the predictor's index.

Parameters:
RESET_VEC, 32'h0000_0000, first fetch address after reset.
INC, 4, sequential increment in bytes.

Ports:
clk  in  1  clock.
reset  in  1  synchronous active-high reset.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch request address.
imem_gnt  in  1  memory accepts request this cycle.
PC_IF  out  32  address of instruction held in IF.
valid_out  out  1  PC_IF valid.
ready_in  in  1  IF/ID accepts PC_IF this cycle.
jump_pred_IF  in  1  predictor says instruction in IF is taken.
jump_addr_IF  in  32  predicted target.
redir_EX  in  1  EX mispredict or JALR redirect.
redir_addr_EX  in  32  corrected target.
trap_taken  in  1  trap/interrupt entry.
trap_addr  in  32  trap vector.
halt_req  in  1  WFI-style fetch halt request.

Behaviour:
- One clock domain. Reset is synchronous and active-high and dominates all other inputs in its cycle.
- Reset values: state=BOOT, fetch_addr=RESET_VEC, PC_IF=RESET_VEC, valid_out=0, imem_req=0.
- Reset asserted mid-operation discards any pending request or IF content next cycle.
- States:
  - BOOT: imem_req=0 for exactly one cycle, then RUN.
  - RUN: imem_req = !(valid_out && !ready_in), i.e. the IF slot is free or is being freed this cycle.
  - IDLE: imem_req=0.
- imem_addr = fetch_addr combinationally.
- accept = imem_req && imem_gnt. handoff = valid_out && ready_in.
- Sequential case (no redirect): on accept, PC_IF<=fetch_addr, valid_out<=1, fetch_addr<=fetch_addr+INC (mod 2^32, wraps FFFF_FFFC->0000_0000). On handoff without accept, valid_out<=0.
- Redirect priority: trap_taken > redir_EX > (handoff && jump_pred_IF).
- Any redirect sets fetch_addr<=target, valid_out<=0, and squashes any same-cycle accept (PC_IF not loaded from it).
- Redirect latency: first redirected request appears the next cycle. Predicted-taken costs exactly one IF bubble.
- Targets are passed unmodified, including bits [1:0]; alignment traps are handled in EX.
- Requests are abortable: imem_addr may change while imem_req=1 && !imem_gnt only on a redirect. Otherwise imem_addr is held stable until grant.
- halt_req in RUN (no same-cycle redirect): go to IDLE, valid_out<=0, fetch_addr unchanged.
- trap_taken in IDLE: fetch_addr<=trap_addr, go to RUN.
- halt_req together with trap_taken: trap wins, stay in RUN.
- jump_pred_IF is ignored when valid_out=0 or ready_in=0. A prediction is acted on only at handoff.

Decomposition:
- Package fetch_pkg: state enum {BOOT, RUN, IDLE}; redirect-source enum {SRC_TRAP, SRC_EX, SRC_PRED, SRC_SEQ}; INC constant.
- Sub-module fetch_redirect_mux: purely combinational priority select producing target and redirect flag. Registers and FSM stay in fetch_pc_gen.

Test Plan:
- Reset, imem_gnt=1, ready_in=1:
  - cycle after release: imem_req=0 (BOOT);
  - then imem_addr=0x0, 0x4, 0x8 on consecutive cycles;
  - PC_IF follows one cycle later with valid_out=1.
- ready_in=0 for 3 cycles with PC_IF=0x8: imem_req=0 and PC_IF holds 0x8. ready_in=1 restarts at imem_addr=0xC with no skipped or duplicated PC.
- PC_IF=0x10, handoff, jump_pred_IF=1, jump_addr_IF=0x40: same-cycle accept of 0x14 squashed; valid_out=0 next cycle; imem_addr=0x40; PC_IF=0x40 one cycle later.
- Same cycle trap_taken (0x100), redir_EX (0x200), predicted taken (0x40): imem_addr=0x100 next cycle. Repeat without trap: 0x200.
- imem_gnt=0 with imem_addr=0x20 pending, then redir_EX to 0x80: imem_addr=0x80 next cycle, and 0x20 never appears on PC_IF.
- halt_req in RUN -> imem_req=0 indefinitely. trap_taken with trap_addr=0x300 -> imem_addr=0x300, RUN resumes. Also cover fetch_addr=0xFFFF_FFFC wrapping to 0x0 and reset asserted while imem_req=1.
